// File: rtl/mont_exp_pkg.sv
// mont_exp_pkg: shared state encoding, default widths and the exp_len width helper
// for the Montgomery-ladder exponentiator.
package mont_exp_pkg;
    localparam int DEF_BITS     = 578;
    localparam int DEF_EXP_BITS = 578;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        MULT = 2'd2,
        DONE = 2'd3
    } state_e;
    function automatic int len_width(input int exp_bits);
        return $clog2(exp_bits + 1);
    endfunction
endpackage

// File: rtl/mont_exp_ladder_param_mm.sv
// montgomery_mult: combinational Montgomery product P = A*B*R^-1 mod N, R = 2^BITS.
// Ports: A, B (operands, < N), N (odd modulus), N_prime (-N^-1 mod R), P (result, < N).
module montgomery_mult
    import mont_exp_pkg::*;
#(
    parameter int BITS = DEF_BITS
) (
    input  logic [BITS-1:0] A,
    input  logic [BITS-1:0] B,
    input  logic [BITS-1:0] N,
    input  logic [BITS-1:0] N_prime,
    output logic [BITS-1:0] P
);
    logic [2*BITS-1:0] t;
    logic [2*BITS-1:0] mn;
    logic [BITS-1:0]   m;
    logic [BITS:0]     r;
    logic [BITS-1:0]   d;
    logic              carry;
    always_comb begin
        t  = {{BITS{1'b0}}, A} * {{BITS{1'b0}}, B};
        m  = t[BITS-1:0] * N_prime;
        mn = {{BITS{1'b0}}, m} * {{BITS{1'b0}}, N};
        // The low halves of t and m*N sum to 0 mod R, so they carry into the
        // high half exactly when they are non-zero (both are zero or neither is).
        carry = (|t[BITS-1:0]) | (|mn[BITS-1:0]);
        r = {1'b0, t[2*BITS-1:BITS]} + {1'b0, mn[2*BITS-1:BITS]} + {{BITS{1'b0}}, carry};
        // r < 2N, so one conditional subtraction suffices; r-N fits in BITS bits.
        d = r[BITS-1:0] - N;
        P = (r >= {1'b0, N}) ? d : r[BITS-1:0];
    end
endmodule

// File: rtl/mont_exp_ladder_param.sv
// mont_exp_ladder_param: constant-time Montgomery-ladder exponentiator, base^e in the
// Montgomery domain, two Montgomery products per exponent bit.
// Ports: clk, rst (async active-high); start/abort control; base_mont, exponent,
// exp_len, N, N_prime, one_mont operands; busy, done (1-cycle pulse), exp_result (held).
module mont_exp_ladder_param
    import mont_exp_pkg::*;
#(
    parameter int BITS     = DEF_BITS,
    parameter int EXP_BITS = DEF_EXP_BITS,
    parameter int LEN_W    = len_width(EXP_BITS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [BITS-1:0]     base_mont,
    input  logic [EXP_BITS-1:0] exponent,
    input  logic [LEN_W-1:0]    exp_len,
    input  logic [BITS-1:0]     N,
    input  logic [BITS-1:0]     N_prime,
    input  logic [BITS-1:0]     one_mont,
    output logic                busy,
    output logic                done,
    output logic [BITS-1:0]     exp_result
);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(EXP_BITS);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);
    state_e              state_q, state_d;
    logic [BITS-1:0]     p0_q, p0_d, p1_q, p1_d, res_q, res_d, n_q, np_q;
    logic [BITS-1:0]     sel, mm0, mm1;
    logic [EXP_BITS-1:0] exp_q;
    logic [LEN_W-1:0]    idx_q, idx_d, len;
    logic                bit_q, bit_d, accept;
    assign accept     = (state_q == IDLE) && start;
    assign len        = (exp_len > MAX_LEN) ? MAX_LEN : exp_len;
    assign sel        = bit_q ? p1_q : p0_q;
    assign exp_result = res_q;
    montgomery_mult #(.BITS(BITS)) u_mm0 (.A(p0_q), .B(sel),  .N(n_q), .N_prime(np_q), .P(mm0));
    montgomery_mult #(.BITS(BITS)) u_mm1 (.A(sel),  .B(p1_q), .N(n_q), .N_prime(np_q), .P(mm1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start ? ((len == '0) ? DONE : SEL) : IDLE;
            SEL:     state_d = abort ? IDLE : MULT;
            MULT:    state_d = abort ? IDLE : ((idx_q == '0) ? DONE : SEL);
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        busy = state_q != IDLE;
        done = state_q == DONE;
    end
    // Both ladder orientations reduce to P0 <- inst0, P1 <- inst1 once the
    // shared operand is steered by cur_bit.
    always_comb begin
        p0_d  = p0_q;
        p1_d  = p1_q;
        idx_d = idx_q;
        bit_d = bit_q;
        if (accept) begin
            p0_d  = one_mont;
            p1_d  = base_mont;
            idx_d = (len == '0) ? '0 : len - ONE_L;
        end else if (state_q == SEL) begin
            bit_d = |(exp_q & ({{(EXP_BITS-1){1'b0}}, 1'b1} << idx_q));
        end else if (state_q == MULT) begin
            p0_d  = mm0;
            p1_d  = mm1;
            idx_d = (idx_q == '0) ? '0 : idx_q - ONE_L;
        end
        // Result is captured on the edge entering DONE so it is valid with the pulse.
        res_d = (state_d == DONE) ? p0_d : res_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_q  <= '0;
            p1_q  <= '0;
            res_q <= '0;
            idx_q <= '0;
            bit_q <= 1'b0;
            exp_q <= '0;
            n_q   <= '0;
            np_q  <= '0;
        end else begin
            p0_q  <= p0_d;
            p1_q  <= p1_d;
            res_q <= res_d;
            idx_q <= idx_d;
            bit_q <= bit_d;
            if (accept) begin
                exp_q <= exponent;
                n_q   <= N;
                np_q  <= N_prime;
            end
        end
    end
endmodule

// File: tb/tb_mont_exp_ladder_param.sv
// tb_mont_exp_ladder_param: directed 16-bit and randomized 578-bit checks of the ladder
// against a plain modular-arithmetic model.
module tb_mont_exp_ladder_param;
    localparam int WB = 578;
    localparam int WL = $clog2(WB + 1);
    typedef logic [WB-1:0] w_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic        s_start = 1'b0, s_abort = 1'b0, s_busy, s_done;
    logic [15:0] s_base = '0, s_exp = '0, s_n = '0, s_np = '0, s_one = '0, s_res;
    logic [4:0]  s_len = '0;
    logic        w_start = 1'b0, w_abort = 1'b0, w_busy, w_done;
    w_t          w_base = '0, w_exp = '0, w_n = '0, w_np = '0, w_one = '0, w_res;
    logic [WL-1:0] w_len = '0;
    int checks = 0;
    int failures = 0;
    mont_exp_ladder_param #(.BITS(16), .EXP_BITS(16)) dut16 (
        .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .base_mont(s_base),
        .exponent(s_exp), .exp_len(s_len), .N(s_n), .N_prime(s_np), .one_mont(s_one),
        .busy(s_busy), .done(s_done), .exp_result(s_res));
    mont_exp_ladder_param #(.BITS(WB), .EXP_BITS(WB)) dut578 (
        .clk(clk), .rst(rst), .start(w_start), .abort(w_abort), .base_mont(w_base),
        .exponent(w_exp), .exp_len(w_len), .N(w_n), .N_prime(w_np), .one_mont(w_one),
        .busy(w_busy), .done(w_done), .exp_result(w_res));
    task automatic chk(input string tag, input w_t got, input w_t want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    function automatic w_t mulmod(input w_t a, input w_t b, input w_t n);
        logic [2*WB-1:0] p;
        p = {{WB{1'b0}}, a} * {{WB{1'b0}}, b};
        p = p % {{WB{1'b0}}, n};
        return p[WB-1:0];
    endfunction
    function automatic w_t r_mod(input w_t n);
        logic [WB:0] r;
        r = '0;
        r[WB] = 1'b1;
        r = r % {1'b0, n};
        return r[WB-1:0];
    endfunction
    function automatic w_t pow_mod(input w_t b, input w_t e, input int len, input w_t n);
        w_t acc = WB'(1);
        for (int i = 0; i < len; i++) begin
            if (e[i]) acc = mulmod(acc, b, n);
            b = mulmod(b, b, n);
        end
        return acc;
    endfunction
    function automatic w_t n_prime(input w_t n);
        w_t x = n;
        for (int i = 0; i < 10; i++) x = x * (WB'(2) - n * x);
        return '0 - x;
    endfunction
    function automatic w_t rand_w();
        w_t v = '0;
        for (int k = 0; k < 19; k++) v = {v[WB-33:0], 32'($urandom)};
        return v;
    endfunction
    task automatic run16(input string tag, input logic [15:0] e, input logic [4:0] len,
                         input logic [15:0] want, input int lat, input bit noise, input bit ab);
        int cyc;
        s_base = 16'd30;
        s_exp = e;
        s_len = len;
        s_abort = ab;
        s_start = 1'b1;
        tick;
        s_start = 1'b0;
        s_abort = 1'b0;
        chk({tag, "_busy"}, WB'(s_busy), WB'(1));
        cyc = 0;
        while (!s_done && cyc < lat + 8) begin
            if (noise) begin
                s_start = 1'($urandom);
                s_exp = 16'($urandom);
                s_len = 5'($urandom);
                s_base = 16'($urandom_range(0, 16'hFFF0));
            end
            tick;
            cyc++;
        end
        s_start = 1'b0;
        chk({tag, "_lat"}, WB'(cyc), WB'(lat));
        chk({tag, "_res"}, WB'(s_res), WB'(want));
        tick;
        chk({tag, "_end"}, WB'({s_done, s_busy}), WB'(0));
    endtask
    task automatic run578(input logic [WL-1:0] len);
        w_t n, b, e, rm, want;
        int l, cyc;
        n = rand_w();
        n[0] = 1'b1;
        n[WB-1] = 1'b1;
        b = rand_w() % n;
        e = rand_w();
        rm = r_mod(n);
        l = (int'(len) > WB) ? WB : int'(len);
        want = mulmod(pow_mod(b, e, l, n), rm, n);
        w_n = n;
        w_np = n_prime(n);
        w_one = rm;
        w_base = mulmod(b, rm, n);
        w_exp = e;
        w_len = len;
        w_start = 1'b1;
        tick;
        w_start = 1'b0;
        cyc = 0;
        while (!w_done && cyc < 2 * l + 8) begin
            tick;
            cyc++;
        end
        chk("rnd_lat", WB'(cyc), WB'(2 * l));
        chk("rnd_res", w_res, want);
        tick;
    endtask
    initial begin
        w_t tmp;
        int seen;
        tmp = n_prime(WB'(16'hFFF1));
        s_np = tmp[15:0];
        s_n = 16'hFFF1;
        s_one = 16'd15;
        s_base = 16'd30;
        rst = 1'b1;
        tick;
        tick;
        chk("rst16", WB'({s_busy, s_done, s_res}), WB'(0));
        chk("rst578", {w_res[WB-1:2], w_busy, w_done}, WB'(0));
        chk("rst578_res", w_res, WB'(0));
        rst = 1'b0;
        tick;
        run16("s1", 16'h000A, 5'd4, 16'd15360, 8, 1'b0, 1'b0);
        run16("s2a", 16'h000A, 5'd16, 16'd15360, 32, 1'b0, 1'b0);
        run16("s2b", 16'hFFF0, 5'd4, 16'd15, 8, 1'b0, 1'b0);
        run16("s3a", 16'hFFFF, 5'd0, 16'd15, 0, 1'b0, 1'b0);
        run16("s3b", 16'h0001, 5'd1, 16'd30, 2, 1'b0, 1'b0);
        run16("clamp", 16'h000A, 5'd31, 16'd15360, 32, 1'b0, 1'b0);
        run16("noise", 16'h000A, 5'd4, 16'd15360, 8, 1'b1, 1'b0);
        run16("st_ab", 16'h0001, 5'd1, 16'd30, 2, 1'b0, 1'b1);
        s_exp = 16'h000A;
        s_len = 5'd4;
        s_start = 1'b1;
        tick;
        s_start = 1'b0;
        repeat (4) tick;
        s_abort = 1'b1;
        tick;
        s_abort = 1'b0;
        chk("abort_busy", WB'(s_busy), WB'(0));
        seen = 0;
        repeat (12) begin
            seen |= int'(s_done);
            tick;
        end
        chk("abort_nodone", WB'(seen), WB'(0));
        chk("abort_res", WB'(s_res), WB'(30));
        s_start = 1'b1;
        tick;
        s_start = 1'b0;
        tick;
        #2 rst = 1'b1;
        #1;
        chk("rst_async", WB'({s_busy, s_done, s_res}), WB'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        tick;
        run16("s5", 16'h000A, 5'd4, 16'd15360, 8, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) run578(WL'($urandom_range(1, WB)));
        run578(WL'(0));
        run578(WL'(WB));
        run578(WL'(700));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
